// File: rtl/pf_dispatch_pkg.sv
// rtl/pf_dispatch_pkg.sv - shared types and helpers for the packet filter dispatcher
// Contents: snooper/forwarder FSM state enums, round-robin pointer width helper.
package pf_dispatch_pkg;

   typedef enum logic [1:0] {
      SIDLE = 2'd0,
      SBUSY = 2'd1,
      SDROP = 2'd2
   } snoop_state_t;

   typedef enum logic {
      FIDLE = 1'b0,
      FBUSY = 1'b1
   } fwd_state_t;

   // Pointer/select width; a single-VM build still needs a 1-bit pointer.
   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/packetfilt_dispatch_if.sv
// rtl/packetfilt_dispatch_if.sv - upstream snooper/forwarder handshake bundle
// master: the snooper/forwarder side (drives writes, reads, done pulses)
// slave : the dispatcher (drives ready flags, read data and packet length)
interface packetfilt_dispatch_if #(
   parameter int PACKET_ADDR_WIDTH = 10,
   parameter int PACKET_DATA_WIDTH = 64
);
   logic [PACKET_ADDR_WIDTH-1:0] snooper_wr_addr;
   logic [PACKET_DATA_WIDTH-1:0] snooper_wr_data;
   logic                         snooper_wr_en;
   logic                         snooper_done;
   logic                         ready_for_snooper;

   logic [PACKET_ADDR_WIDTH-1:0] forwarder_rd_addr;
   logic                         forwarder_rd_en;
   logic                         forwarder_done;
   logic [PACKET_DATA_WIDTH-1:0] forwarder_rd_data;
   logic                         ready_for_forwarder;
   logic [PACKET_ADDR_WIDTH-1:0] len_to_forwarder;

   modport master (
      output snooper_wr_addr, snooper_wr_data, snooper_wr_en, snooper_done,
      input  ready_for_snooper,
      output forwarder_rd_addr, forwarder_rd_en, forwarder_done,
      input  forwarder_rd_data, ready_for_forwarder, len_to_forwarder
   );

   modport slave (
      input  snooper_wr_addr, snooper_wr_data, snooper_wr_en, snooper_done,
      output ready_for_snooper,
      input  forwarder_rd_addr, forwarder_rd_en, forwarder_done,
      output forwarder_rd_data, ready_for_forwarder, len_to_forwarder
   );
endinterface

// File: rtl/pf_rr_arbiter.sv
// rtl/pf_rr_arbiter.sv - combinational rotating-priority arbiter
// req[N]    : request vector
// ptr       : index with highest priority this cycle
// grant_valid/grant_idx : first requester at or after ptr (wrapping)
module pf_rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          grant_valid,
   output logic [PW-1:0] grant_idx
);

   // Scan from farthest to nearest so the requester closest to ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            grant_valid = 1'b1;
            grant_idx   = PW'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/packetfilt_dispatch.sv
// rtl/packetfilt_dispatch.sv - fans snooper/forwarder streams across N_VMS packet filter VMs
// clk, rst           : clock, synchronous active-high reset
// start              : low holds VMs in reset and rewinds the code address
// inst_low/high_*    : instruction words; high strobe commits a 64-bit code write
// drop_clr           : clears the drop counter
// num_packets_dropped: saturating count of packets with no free VM
// vm_rst             : registered rst | ~start
// code_mem_wr_*      : code write broadcast to every VM
// up                 : upstream snooper/forwarder handshake (slave side)
// vm_snooper_*       : per-VM snooper side (data broadcast, enables one-hot)
// vm_forwarder_*     : per-VM forwarder side (address broadcast, enables one-hot)
module packetfilt_dispatch
   import pf_dispatch_pkg::*;
#(
   parameter int N_VMS             = 4,
   parameter int PACKET_ADDR_WIDTH = 10,
   parameter int PACKET_DATA_WIDTH = 64,
   parameter int CODE_ADDR_WIDTH   = 10,
   parameter int DROP_CNT_WIDTH    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [31:0]                          inst_low_value,
   input  logic                                 inst_low_strobe,
   input  logic [31:0]                          inst_high_value,
   input  logic                                 inst_high_strobe,
   input  logic                                 drop_clr,
   output logic [DROP_CNT_WIDTH-1:0]            num_packets_dropped,
   output logic                                 vm_rst,
   output logic [CODE_ADDR_WIDTH-1:0]           code_mem_wr_addr,
   output logic [63:0]                          code_mem_wr_data,
   output logic                                 code_mem_wr_en,
   packetfilt_dispatch_if.slave                 up,
   output logic [PACKET_ADDR_WIDTH-1:0]         vm_snooper_wr_addr,
   output logic [PACKET_DATA_WIDTH-1:0]         vm_snooper_wr_data,
   output logic [N_VMS-1:0]                     vm_snooper_wr_en,
   output logic [N_VMS-1:0]                     vm_snooper_done,
   input  logic [N_VMS-1:0]                     vm_ready_for_snooper,
   output logic [PACKET_ADDR_WIDTH-1:0]         vm_forwarder_rd_addr,
   output logic [N_VMS-1:0]                     vm_forwarder_rd_en,
   output logic [N_VMS-1:0]                     vm_forwarder_done,
   input  logic [N_VMS*PACKET_DATA_WIDTH-1:0]   vm_forwarder_rd_data,
   input  logic [N_VMS*PACKET_ADDR_WIDTH-1:0]   vm_len_to_forwarder,
   input  logic [N_VMS-1:0]                     vm_ready_for_forwarder
);

   localparam int            PW   = ptr_w(N_VMS);
   localparam logic [PW-1:0] LAST = PW'(N_VMS - 1);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // ---------------- code loader ----------------
   logic [31:0]                low_latched;
   logic [31:0]                low_word;
   logic [CODE_ADDR_WIDTH-1:0] code_addr;

   // A low strobe in the same cycle as the high strobe takes effect immediately.
   assign low_word = inst_low_strobe ? inst_low_value : low_latched;

   always_ff @(posedge clk) begin
      if (rst) begin
         low_latched      <= '0;
         code_addr        <= '0;
         code_mem_wr_en   <= 1'b0;
         code_mem_wr_addr <= '0;
         code_mem_wr_data <= '0;
         vm_rst           <= 1'b1;
      end else begin
         vm_rst         <= ~start;
         code_mem_wr_en <= inst_high_strobe;
         if (inst_low_strobe)
            low_latched <= inst_low_value;
         if (inst_high_strobe) begin
            code_mem_wr_data <= {inst_high_value, low_word};
            code_mem_wr_addr <= start ? code_addr : '0;
         end
         if (!start)
            code_addr <= '0;
         else if (inst_high_strobe)
            code_addr <= code_addr + 1'b1;
      end
   end

   // ---------------- snooper side ----------------
   snoop_state_t s_state, s_next;
   logic [PW-1:0] s_sel, s_ptr, s_gidx;
   logic          s_gv, s_drop;

   pf_rr_arbiter #(.N(N_VMS), .PW(PW)) u_snoop_arb (
      .req         (vm_ready_for_snooper),
      .ptr         (s_ptr),
      .grant_valid (s_gv),
      .grant_idx   (s_gidx)
   );

   assign vm_snooper_wr_addr = up.snooper_wr_addr;
   assign vm_snooper_wr_data = up.snooper_wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_state <= SIDLE;
         s_sel   <= '0;
         s_ptr   <= '0;
      end else begin
         s_state <= s_next;
         if (s_state == SIDLE && up.snooper_wr_en && s_gv) begin
            s_sel <= s_gidx;
            if (up.snooper_done)
               s_ptr <= ptr_inc(s_gidx);
         end else if (s_state == SBUSY && up.snooper_done) begin
            s_ptr <= ptr_inc(s_sel);
         end
      end
   end

   always_comb begin
      s_next = s_state;
      case (s_state)
         SIDLE:        if (up.snooper_wr_en && !up.snooper_done)
                          s_next = s_gv ? SBUSY : SDROP;
         SBUSY, SDROP: if (up.snooper_done) s_next = SIDLE;
         default:      s_next = SIDLE;
      endcase
   end

   // The first word of a packet is routed in the cycle it arrives, using the live grant.
   always_comb begin
      vm_snooper_wr_en     = '0;
      vm_snooper_done      = '0;
      up.ready_for_snooper = 1'b0;
      s_drop               = 1'b0;
      if (!rst) begin
         case (s_state)
            SIDLE: begin
               up.ready_for_snooper = |vm_ready_for_snooper;
               if (up.snooper_wr_en) begin
                  if (s_gv) begin
                     vm_snooper_wr_en[s_gidx] = 1'b1;
                     vm_snooper_done[s_gidx]  = up.snooper_done;
                  end else begin
                     s_drop = 1'b1;
                  end
               end
            end
            SBUSY: begin
               up.ready_for_snooper    = vm_ready_for_snooper[s_sel];
               vm_snooper_wr_en[s_sel] = up.snooper_wr_en;
               vm_snooper_done[s_sel]  = up.snooper_done;
            end
            SDROP:   up.ready_for_snooper = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         num_packets_dropped <= '0;
      else if (drop_clr)
         num_packets_dropped <= s_drop ? DROP_CNT_WIDTH'(1) : '0;
      else if (s_drop && num_packets_dropped != '1)
         num_packets_dropped <= num_packets_dropped + 1'b1;
   end

   // ---------------- forwarder side ----------------
   fwd_state_t    f_state, f_next;
   logic [PW-1:0] f_sel, f_ptr, f_gidx;
   logic          f_gv;

   pf_rr_arbiter #(.N(N_VMS), .PW(PW)) u_fwd_arb (
      .req         (vm_ready_for_forwarder),
      .ptr         (f_ptr),
      .grant_valid (f_gv),
      .grant_idx   (f_gidx)
   );

   assign vm_forwarder_rd_addr = up.forwarder_rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         f_state <= FIDLE;
         f_sel   <= '0;
         f_ptr   <= '0;
      end else begin
         f_state <= f_next;
         if (f_state == FIDLE && f_gv)
            f_sel <= f_gidx;
         else if (f_state == FBUSY && up.forwarder_done)
            f_ptr <= ptr_inc(f_sel);
      end
   end

   always_comb begin
      f_next = f_state;
      case (f_state)
         FIDLE:   if (f_gv) f_next = FBUSY;
         FBUSY:   if (up.forwarder_done) f_next = FIDLE;
         default: f_next = FIDLE;
      endcase
   end

   // Data/length mux follows f_sel in every state: f_sel only changes on a new
   // grant, so a read issued on the done cycle still returns the right VM's data.
   always_comb begin
      vm_forwarder_rd_en     = '0;
      vm_forwarder_done      = '0;
      up.ready_for_forwarder = 1'b0;
      up.forwarder_rd_data   = vm_forwarder_rd_data[int'(f_sel)*PACKET_DATA_WIDTH +: PACKET_DATA_WIDTH];
      up.len_to_forwarder    = vm_len_to_forwarder[int'(f_sel)*PACKET_ADDR_WIDTH +: PACKET_ADDR_WIDTH];
      if (!rst && f_state == FBUSY) begin
         up.ready_for_forwarder    = vm_ready_for_forwarder[f_sel];
         vm_forwarder_rd_en[f_sel] = up.forwarder_rd_en;
         vm_forwarder_done[f_sel]  = up.forwarder_done;
      end
   end

endmodule

// File: tb/tb_packetfilt_dispatch.sv
// tb/tb_packetfilt_dispatch.sv - self-checking bench for packetfilt_dispatch
module tb_packetfilt_dispatch;

   localparam int N    = 4;
   localparam int AW   = 10;
   localparam int DW   = 64;
   localparam int CAW  = 10;
   localparam int DCW  = 5;
   localparam int DMAX = (1 << DCW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, start;
   logic [31:0]      inst_low_value, inst_high_value;
   logic             inst_low_strobe, inst_high_strobe, drop_clr;
   logic [DCW-1:0]   num_packets_dropped;
   logic             vm_rst;
   logic [CAW-1:0]   code_mem_wr_addr;
   logic [63:0]      code_mem_wr_data;
   logic             code_mem_wr_en;
   logic [AW-1:0]    vm_snooper_wr_addr;
   logic [DW-1:0]    vm_snooper_wr_data;
   logic [N-1:0]     vm_snooper_wr_en, vm_snooper_done, vm_ready_for_snooper;
   logic [AW-1:0]    vm_forwarder_rd_addr;
   logic [N-1:0]     vm_forwarder_rd_en, vm_forwarder_done, vm_ready_for_forwarder;
   logic [N*DW-1:0]  vm_forwarder_rd_data;
   logic [N*AW-1:0]  vm_len_to_forwarder;

   packetfilt_dispatch_if #(.PACKET_ADDR_WIDTH(AW), .PACKET_DATA_WIDTH(DW)) bus ();

   packetfilt_dispatch #(
      .N_VMS(N), .PACKET_ADDR_WIDTH(AW), .PACKET_DATA_WIDTH(DW),
      .CODE_ADDR_WIDTH(CAW), .DROP_CNT_WIDTH(DCW)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .inst_low_value(inst_low_value), .inst_low_strobe(inst_low_strobe),
      .inst_high_value(inst_high_value), .inst_high_strobe(inst_high_strobe),
      .drop_clr(drop_clr), .num_packets_dropped(num_packets_dropped), .vm_rst(vm_rst),
      .code_mem_wr_addr(code_mem_wr_addr), .code_mem_wr_data(code_mem_wr_data),
      .code_mem_wr_en(code_mem_wr_en), .up(bus),
      .vm_snooper_wr_addr(vm_snooper_wr_addr), .vm_snooper_wr_data(vm_snooper_wr_data),
      .vm_snooper_wr_en(vm_snooper_wr_en), .vm_snooper_done(vm_snooper_done),
      .vm_ready_for_snooper(vm_ready_for_snooper),
      .vm_forwarder_rd_addr(vm_forwarder_rd_addr), .vm_forwarder_rd_en(vm_forwarder_rd_en),
      .vm_forwarder_done(vm_forwarder_done), .vm_forwarder_rd_data(vm_forwarder_rd_data),
      .vm_len_to_forwarder(vm_len_to_forwarder), .vm_ready_for_forwarder(vm_ready_for_forwarder)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int s_ptr_m = 0;
   int f_ptr_m = 0;
   int drop_m  = 0;
   int code_m  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // first set bit of m at or after p, wrapping; -1 when none
   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++)
         if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int v);
      logic [N-1:0] r;
      r = '0;
      if (v >= 0) r[v] = 1'b1;
      return r;
   endfunction

   task automatic code_write(input logic [31:0] lo, input logic [31:0] hi, input bit same_cycle);
      logic [63:0] exp_data;
      if (!same_cycle) begin
         inst_low_value = lo; inst_low_strobe = 1'b1;
         cyc();
         inst_low_strobe = 1'b0;
      end else begin
         inst_low_value = lo; inst_low_strobe = 1'b1;
      end
      inst_high_value = hi; inst_high_strobe = 1'b1;
      cyc();
      inst_low_strobe = 1'b0; inst_high_strobe = 1'b0;
      exp_data = {hi, lo};
      check("code_wr_en", code_mem_wr_en, 1);
      check("code_wr_addr", code_mem_wr_addr, code_m);
      check("code_wr_data", code_mem_wr_data, exp_data);
      code_m = (code_m + 1) % (1 << CAW);
   endtask

   task automatic send_snoop(input int len, input logic [N-1:0] mask);
      int vm;
      logic [N-1:0] exp_en;
      vm_ready_for_snooper = mask;
      #1;
      check("snoop_idle_ready", bus.ready_for_snooper, |mask);
      vm = pick(mask, s_ptr_m);
      exp_en = onehot(vm);
      for (int w = 0; w < len; w++) begin
         bus.snooper_wr_en   = 1'b1;
         bus.snooper_wr_addr = AW'(w);
         bus.snooper_wr_data = {$urandom, $urandom};
         bus.snooper_done    = (w == len - 1);
         #1;
         check("snoop_wr_en", vm_snooper_wr_en, exp_en);
         check("snoop_done", vm_snooper_done, (w == len - 1) ? exp_en : '0);
         if (vm >= 0) check("snoop_wr_data", vm_snooper_wr_data, bus.snooper_wr_data);
         if (w > 0 && vm < 0) check("snoop_drop_ready", bus.ready_for_snooper, 1);
         cyc();
      end
      bus.snooper_wr_en = 1'b0;
      bus.snooper_done  = 1'b0;
      if (vm < 0) drop_m = (drop_m < DMAX) ? drop_m + 1 : DMAX;
      else        s_ptr_m = (vm + 1) % N;
      check("drop_count", num_packets_dropped, drop_m);
   endtask

   task automatic send_fwd(input logic [N-1:0] mask, input int nreads);
      int vm;
      logic [N-1:0] exp_en;
      vm_ready_for_forwarder = mask;
      for (int i = 0; i < N; i++) vm_len_to_forwarder[i*AW +: AW] = AW'($urandom);
      #1;
      check("fwd_idle_ready", bus.ready_for_forwarder, 0);
      vm = pick(mask, f_ptr_m);
      exp_en = onehot(vm);
      cyc();
      check("fwd_busy_ready", bus.ready_for_forwarder, 1);
      check("fwd_len", bus.len_to_forwarder, vm_len_to_forwarder[vm*AW +: AW]);
      for (int r = 0; r < nreads; r++) begin
         bus.forwarder_rd_en   = 1'b1;
         bus.forwarder_rd_addr = AW'($urandom);
         for (int i = 0; i < N; i++) vm_forwarder_rd_data[i*DW +: DW] = {$urandom, $urandom};
         #1;
         check("fwd_rd_en", vm_forwarder_rd_en, exp_en);
         check("fwd_rd_addr", vm_forwarder_rd_addr, bus.forwarder_rd_addr);
         check("fwd_rd_data", bus.forwarder_rd_data, vm_forwarder_rd_data[vm*DW +: DW]);
         cyc();
      end
      bus.forwarder_rd_en = 1'b0;
      bus.forwarder_done  = 1'b1;
      #1;
      check("fwd_done", vm_forwarder_done, exp_en);
      cyc();
      bus.forwarder_done     = 1'b0;
      vm_ready_for_forwarder = '0;
      #1;
      check("fwd_after_done_ready", bus.ready_for_forwarder, 0);
      f_ptr_m = (vm + 1) % N;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      inst_low_value = '0; inst_high_value = '0;
      inst_low_strobe = 1'b0; inst_high_strobe = 1'b0; drop_clr = 1'b0;
      vm_ready_for_snooper = '0; vm_ready_for_forwarder = '0;
      vm_forwarder_rd_data = '0; vm_len_to_forwarder = '0;
      bus.snooper_wr_addr = '0; bus.snooper_wr_data = '0;
      bus.snooper_wr_en = 1'b0; bus.snooper_done = 1'b0;
      bus.forwarder_rd_addr = '0; bus.forwarder_rd_en = 1'b0; bus.forwarder_done = 1'b0;

      // reset state
      cyc(); cyc();
      check("rst_vm_rst", vm_rst, 1);
      check("rst_code_wr_en", code_mem_wr_en, 0);
      check("rst_drop", num_packets_dropped, 0);
      check("rst_snoop_en", vm_snooper_wr_en, 0);
      check("rst_fwd_ready", bus.ready_for_forwarder, 0);

      rst = 1'b0; start = 1'b1;
      cyc();
      check("vm_rst_released", vm_rst, 0);

      // code loading
      code_write(32'h11, 32'h22, 1'b0);
      code_write(32'h33, 32'h44, 1'b0);
      cyc();
      check("code_wr_en_idle", code_mem_wr_en, 0);
      code_write(32'h55, 32'h66, 1'b1);
      start = 1'b0;
      cyc();
      check("vm_rst_start_low", vm_rst, 1);
      start = 1'b1;
      code_m = 0;
      inst_high_value = 32'h77; inst_high_strobe = 1'b1;
      cyc();
      inst_high_strobe = 1'b0;
      check("rewind_addr", code_mem_wr_addr, 0);
      check("rewind_data", code_mem_wr_data, 64'h00000077_00000055);
      check("vm_rst_start_high", vm_rst, 0);
      code_m = 1;
      for (int i = 0; i < 4; i++) code_write($urandom, $urandom, 1'($urandom));

      // round-robin snoop, then a one-word packet
      for (int p = 0; p < 3; p++) send_snoop(4, 4'hF);
      send_snoop(1, 4'hF);

      // drops, saturation, clear
      send_snoop(3, 4'h0);
      for (int i = 0; i < DMAX + 2; i++) send_snoop(1, 4'h0);
      bus.snooper_wr_en = 1'b1; bus.snooper_done = 1'b1; drop_clr = 1'b1;
      cyc();
      bus.snooper_wr_en = 1'b0; bus.snooper_done = 1'b0;
      drop_m = 1;
      check("clr_with_drop", num_packets_dropped, 1);
      cyc();
      drop_clr = 1'b0;
      drop_m = 0;
      check("clr_alone", num_packets_dropped, 0);

      // skip busy VM: bring pointer to 1, then only VM0 and VM3 ready
      send_snoop(2, 4'b0001);
      send_snoop(3, 4'b1001);

      // done in SIDLE without a write is ignored
      bus.snooper_done = 1'b1;
      #1;
      check("idle_done_ignored", vm_snooper_done, 0);
      cyc();
      bus.snooper_done = 1'b0;

      // forwarder: VM2 first, then pointer-driven choices
      send_fwd(4'b0100, 3);
      send_fwd(4'b1001, 2);
      send_fwd(4'b1111, 1);
      bus.forwarder_done = 1'b1;
      #1;
      check("fwd_idle_done_ignored", vm_forwarder_done, 0);
      cyc();
      bus.forwarder_done = 1'b0;

      // randomized traffic
      for (int i = 0; i < 20; i++) begin
         logic [N-1:0] m;
         m = N'($urandom);
         if ($urandom_range(0, 4) == 0) m = '0;
         send_snoop($urandom_range(1, 5), m);
      end
      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] m;
         m = N'($urandom_range(1, (1 << N) - 1));
         send_fwd(m, $urandom_range(0, 3));
      end

      // reset mid-packet
      vm_ready_for_snooper = 4'hF;
      bus.snooper_wr_en = 1'b1; bus.snooper_wr_data = {$urandom, $urandom};
      cyc(); cyc();
      rst = 1'b1;
      #1;
      check("rst_gate_en", vm_snooper_wr_en, 0);
      cyc();
      rst = 1'b0;
      bus.snooper_wr_en = 1'b0;
      s_ptr_m = 0; f_ptr_m = 0; drop_m = 0; code_m = 0;
      #1;
      check("post_rst_snoop_en", vm_snooper_wr_en, 0);
      check("post_rst_snoop_done", vm_snooper_done, 0);
      check("post_rst_fwd_en", vm_forwarder_rd_en, 0);
      check("post_rst_fwd_done", vm_forwarder_done, 0);
      check("post_rst_drop", num_packets_dropped, 0);
      check("post_rst_vm_rst", vm_rst, 1);
      cyc();
      send_snoop(2, 4'b0110);
      send_snoop(1, 4'hF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/packetfilt_dispatch.md
Name: packetfilt_dispatch

Overview:
- Parametrised successor to the single-VM packet filter top level. Fans one snooper stream and one forwarder stream across N_VMS bpfvm instances, with round-robin load balancing on both sides.
- Broadcasts instruction loads from the inst_low/inst_high register strobes to every VM's code memory, using an auto-incrementing address.
- Counts packets dropped because no VM was free.
- Sits between the AXI register block and the bank of bpfvm instances.

Parameters:
- N_VMS, 4, number of VMs (>=1)
- PACKET_ADDR_WIDTH, 10, packet word address width
- PACKET_DATA_WIDTH, 64, snooper/forwarder data width
- CODE_ADDR_WIDTH, 10, code memory address width
- DROP_CNT_WIDTH, 16, drop counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  control_start; low holds VMs in reset and rewinds the code address
- inst_low_value  in  32  low instruction word
- inst_low_strobe  in  1  write pulse for inst_low
- inst_high_value  in  32  high instruction word
- inst_high_strobe  in  1  write pulse; commits the instruction
- drop_clr  in  1  clears the drop counter (wire to status_strobe)
- num_packets_dropped  out  DROP_CNT_WIDTH  saturating drop count
- vm_rst  out  1  rst | ~start, registered
- code_mem_wr_addr  out  CODE_ADDR_WIDTH  broadcast
- code_mem_wr_data  out  64  broadcast
- code_mem_wr_en  out  1  broadcast
- snooper_wr_addr  in  PACKET_ADDR_WIDTH
- snooper_wr_data  in  PACKET_DATA_WIDTH
- snooper_wr_en  in  1
- snooper_done  in  1  1-cycle pulse
- ready_for_snooper  out  1
- vm_snooper_wr_addr  out  PACKET_ADDR_WIDTH  broadcast
- vm_snooper_wr_data  out  PACKET_DATA_WIDTH  broadcast
- vm_snooper_wr_en  out  N_VMS  one-hot
- vm_snooper_done  out  N_VMS  one-hot
- vm_ready_for_snooper  in  N_VMS
- forwarder_rd_addr  in  PACKET_ADDR_WIDTH
- forwarder_rd_en  in  1
- forwarder_done  in  1  1-cycle pulse
- forwarder_rd_data  out  PACKET_DATA_WIDTH
- ready_for_forwarder  out  1
- len_to_forwarder  out  PACKET_ADDR_WIDTH
- vm_forwarder_rd_addr  out  PACKET_ADDR_WIDTH  broadcast
- vm_forwarder_rd_en  out  N_VMS  one-hot
- vm_forwarder_done  out  N_VMS  one-hot
- vm_forwarder_rd_data  in  N_VMS*PACKET_DATA_WIDTH
- vm_len_to_forwarder  in  N_VMS*PACKET_ADDR_WIDTH
- vm_ready_for_forwarder  in  N_VMS

Behaviour:
- Reset (rst=1): both FSMs go to IDLE; round-robin pointers, code address, and drop counter go to 0; code_mem_wr_en=0; every one-hot output is 0; vm_rst=1. Reset mid-packet abandons the packet without counting a drop.
- Code loader:
  - inst_low_strobe latches the low word.
  - inst_high_strobe produces code_mem_wr_en=1 on the next cycle, with data={high,low_latched} and addr=code_addr; code_addr then increments and wraps at 2^CODE_ADDR_WIDTH.
  - While start=0, code_addr is held at 0 and strobes still write, at address 0.
  - If both strobes arrive in the same cycle, the new low word is used.
- Snooper FSM (SIDLE, SBUSY, SDROP):
  - SIDLE: ready_for_snooper = |vm_ready_for_snooper.
  - First snooper_wr_en in SIDLE, with a ready VM: the round-robin arbiter picks the first ready VM at or after s_ptr. That write is routed combinationally in the same cycle, sel is registered, and the FSM goes to SBUSY.
  - First write in SIDLE with no VM ready: no VM sees the write; drop counter +1 (saturating); go to SDROP.
  - SBUSY: wr_en and done are routed to vm[sel]; ready_for_snooper = vm_ready_for_snooper[sel]. On done: go to SIDLE, s_ptr = (sel+1) mod N_VMS.
  - SDROP: writes are discarded; ready_for_snooper = 1; on done go to SIDLE and s_ptr is unchanged.
  - Write and done in the same cycle from SIDLE: this is a one-word packet, handled as above but the FSM stays in SIDLE.
  - done in SIDLE without wr_en is ignored.
- Forwarder FSM (FIDLE, FBUSY):
  - FIDLE: if any vm_ready_for_forwarder is set, arbitrate from f_ptr, register fsel, and go to FBUSY. ready_for_forwarder=0 in FIDLE.
  - FBUSY: ready_for_forwarder = vm_ready_for_forwarder[fsel]; len_to_forwarder and forwarder_rd_data are muxed from fsel; rd_en and done are routed to fsel. rd_data keeps the VM's 1-cycle read latency, because fsel is stable.
  - On done: go to FIDLE, f_ptr = (fsel+1) mod N_VMS.
  - done in FIDLE is ignored.
  - Minimum turnaround: 1 idle cycle between packets.
- Drop counter: saturates at all-ones. drop_clr and a drop in the same cycle give 1; drop_clr alone gives 0.
- N_VMS=1: pointer width is max(1,$clog2(N_VMS)) and the pointer stays at 0.

Decomposition:
- Package pf_dispatch_pkg holds:
  - snoop state enum (SIDLE/SBUSY/SDROP)
  - fwd state enum (FIDLE/FBUSY)
  - the PTR_W function
- One sub-module, pf_rr_arbiter (req[N], ptr → grant_valid, grant_idx; combinational priority rotation starting at ptr), instantiated twice.

Test Plan:
- Code load: start=1, then pairs (low=0x11,high=0x22) and (0x33,0x44) → code writes at addr 0 data 0x00000022_00000011 and addr 1 data 0x00000044_00000033. Deassert and reassert start; the next write goes to addr 0.
- Round-robin snoop: N=4, all ready, three 4-word packets → vm_snooper_wr_en one-hot goes to VM0, then VM1, then VM2; the first word of each packet goes out in the same cycle.
- Drop: vm_ready_for_snooper=0, 3-word packet → no vm wr_en; num_packets_dropped=1. With counter at 0xFFFF, another drop leaves it at 0xFFFF. drop_clr together with a drop gives 1.
- Skip busy VM: s_ptr=1, ready=4'b1001 → VM3 is granted; s_ptr becomes 0 after done.
- Forwarder: VM2 ready with len=37 → ready_for_forwarder rises 1 cycle later with len_to_forwarder=37; rd_en reaches only VM2 and its rd_data passes through; on done, f_ptr=3 and ready drops.
- One-word packet, plus rst asserted mid-packet in SBUSY → FSM in SIDLE, no drop counted, all one-hot outputs 0 on the next cycle.
